// File: rtl/minimac_pkg.sv
// minimac_pkg: register offsets, slot state encodings and status/mask bit indices for the minimac control interface
package minimac_pkg;
  localparam logic [5:0] REG_STATUS = 6'd0;
  localparam logic [5:0] REG_MDIO   = 6'd1;
  localparam logic [5:0] REG_MASK   = 6'd2;
  localparam logic [5:0] REG_TXADR  = 6'd3;
  localparam logic [5:0] REG_TXREM  = 6'd4;
  localparam int REG_SLOT_STATE = 8;
  localparam int REG_SLOT_ADR   = 9;
  localparam int SLOT_STRIDE    = 4;
  localparam int ST_RX  = 0;
  localparam int ST_OVF = 1;
  localparam int ST_TX  = 2;
  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'b00,
    SLOT_LOADED  = 2'b01,
    SLOT_RXED    = 2'b10,
    SLOT_INVALID = 2'b11
  } slot_state_t;
endpackage

// File: rtl/minimac_ctlif_nslot_if.sv
// minimac_ctlif_nslot_if: CSR bus plus RX/TX DMA handshake between the MAC engines and the control interface
interface minimac_ctlif_nslot_if #(parameter int ADDR_W = 30);
  logic [13:0]       csr_a;
  logic              csr_we;
  logic [31:0]       csr_di;
  logic [31:0]       csr_do;
  logic              rx_valid;
  logic [ADDR_W-1:0] rx_adr;
  logic              rx_resetcount;
  logic              rx_incrcount;
  logic              rx_endframe;
  logic              fifo_full;
  logic              tx_valid;
  logic [ADDR_W-1:0] tx_adr;
  logic              tx_next;
  modport master (
    output csr_a, csr_we, csr_di, rx_resetcount, rx_incrcount, rx_endframe, fifo_full, tx_next,
    input  csr_do, rx_valid, rx_adr, tx_valid, tx_adr
  );
  modport slave (
    input  csr_a, csr_we, csr_di, rx_resetcount, rx_incrcount, rx_endframe, fifo_full, tx_next,
    output csr_do, rx_valid, rx_adr, tx_valid, tx_adr
  );
endinterface

// File: rtl/minimac_rx_slot.sv
// minimac_rx_slot: one RX descriptor (state, buffer address, saturating byte count)
module minimac_rx_slot import minimac_pkg::*; #(
  parameter int ADDR_W  = 30,
  parameter int COUNT_W = 11
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               we_state,
  input  logic               we_adr,
  input  logic [1:0]         state_di,
  input  logic [ADDR_W-1:0]  adr_di,
  input  logic               active,
  input  logic               rx_resetcount,
  input  logic               rx_incrcount,
  input  logic               rx_endframe,
  output logic [1:0]         state,
  output logic [ADDR_W-1:0]  adr,
  output logic [COUNT_W-1:0] count,
  output logic               loaded
);
  logic cnt_ev;
  assign cnt_ev = active && (rx_resetcount || rx_incrcount);
  assign loaded = state == SLOT_LOADED;
  // RX events on the active slot take priority over a same-cycle CSR state write
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state <= '0;
      adr   <= '0;
      count <= '0;
    end else begin
      state <= active && rx_endframe ? SLOT_RXED : we_state ? state_di : state;
      adr   <= we_adr ? adr_di : adr;
      count <= cnt_ev ? (rx_resetcount ? COUNT_W'(rx_incrcount) : (&count ? count : count + 1'b1))
             : we_state ? '0 : count;
    end
endmodule

// File: rtl/minimac_ctlif_nslot.sv
// minimac_ctlif_nslot: CSR bank, MDIO bit-bang, N-slot round-robin RX ring, TX descriptor and interrupts
module minimac_ctlif_nslot import minimac_pkg::*; #(
  parameter int N_RX_SLOTS = 4,
  parameter int ADDR_W     = 30,
  parameter int COUNT_W    = 11
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic irq_rx,
  output logic irq_tx,
  output logic phy_mii_clk,
  inout  wire  phy_mii_data,
  minimac_ctlif_nslot_if.slave bus
);
  localparam int RR_W = N_RX_SLOTS > 1 ? $clog2(N_RX_SLOTS) : 1;
  logic [5:0] a;
  logic [3:0] slot;
  logic wr_stat, wr_mdio, wr_mask, wr_txadr, wr_txrem, tx_step, found, unused_a;
  logic [2:0] stat, mask, set_evt, w1c;
  logic mdio_clk, mdio_oe, mdio_do, mdi_s1, mdi_s2, tx_valid_q;
  logic [ADDR_W-1:0] tx_adr_q;
  logic [COUNT_W-1:0] tx_rem;
  logic [RR_W-1:0] rr, act;
  logic [31:0] rdata;
  logic [N_RX_SLOTS-1:0] loaded, we_state, we_adr, is_act;
  logic [1:0] slot_st [N_RX_SLOTS];
  logic [ADDR_W-1:0] slot_adr [N_RX_SLOTS];
  logic [COUNT_W-1:0] slot_cnt [N_RX_SLOTS];
  assign a        = bus.csr_a[5:0];
  assign unused_a = ^bus.csr_a[13:6];
  assign slot     = a[5:2] - 4'd2;
  assign wr_stat  = bus.csr_we && a == REG_STATUS;
  assign wr_mdio  = bus.csr_we && a == REG_MDIO;
  assign wr_mask  = bus.csr_we && a == REG_MASK;
  assign wr_txadr = bus.csr_we && a == REG_TXADR;
  assign wr_txrem = bus.csr_we && a == REG_TXREM;
  assign w1c      = wr_stat ? bus.csr_di[2:0] : 3'd0;
  assign bus.tx_valid = tx_rem != '0;
  assign bus.tx_adr   = tx_adr_q;
  assign bus.rx_valid = found;
  assign tx_step  = bus.tx_next && bus.tx_valid;
  assign set_evt  = {tx_valid_q && !bus.tx_valid, bus.fifo_full, bus.rx_endframe && found};
  assign phy_mii_clk  = mdio_clk;
  assign phy_mii_data = mdio_oe ? mdio_do : 1'bz;
  for (genvar i = 0; i < N_RX_SLOTS; i++) begin : g_slot
    assign we_state[i] = bus.csr_we && a == 6'(REG_SLOT_STATE + SLOT_STRIDE * i);
    assign we_adr[i]   = bus.csr_we && a == 6'(REG_SLOT_ADR + SLOT_STRIDE * i);
    assign is_act[i]   = found && act == RR_W'(i);
    minimac_rx_slot #(.ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) u_slot (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .we_state(we_state[i]), .we_adr(we_adr[i]),
      .state_di(bus.csr_di[1:0]), .adr_di(bus.csr_di[ADDR_W+1:2]),
      .active(is_act[i]),
      .rx_resetcount(bus.rx_resetcount), .rx_incrcount(bus.rx_incrcount), .rx_endframe(bus.rx_endframe),
      .state(slot_st[i]), .adr(slot_adr[i]), .count(slot_cnt[i]), .loaded(loaded[i])
    );
  end
  // Descending distance from rr so the nearest loaded slot is the last (winning) assignment
  always_comb begin
    found = 1'b0;
    act = '0;
    bus.rx_adr = '0;
    for (int k = N_RX_SLOTS - 1; k >= 0; k--)
      for (int i = 0; i < N_RX_SLOTS; i++)
        if (loaded[i] && i == (int'(rr) + k) % N_RX_SLOTS) begin
          found = 1'b1;
          act = RR_W'(i);
        end
    for (int i = 0; i < N_RX_SLOTS; i++)
      if (is_act[i]) bus.rx_adr = slot_adr[i];
  end
  always_comb begin
    rdata = '0;
    case (a)
      REG_STATUS: rdata = 32'(stat);
      REG_MDIO:   rdata = {28'd0, mdio_clk, mdio_oe, mdi_s2, mdio_do};
      REG_MASK:   rdata = 32'(mask);
      REG_TXADR:  rdata = 32'({tx_adr_q, 2'b00});
      REG_TXREM:  rdata = 32'(tx_rem);
      default:    rdata = '0;
    endcase
    for (int i = 0; i < N_RX_SLOTS; i++)
      if (a >= 6'(REG_SLOT_STATE) && slot == 4'(i))
        rdata = a[1:0] == 2'd0 ? 32'(slot_st[i]) : a[1:0] == 2'd1 ? 32'({slot_adr[i], 2'b00})
              : a[1:0] == 2'd2 ? 32'(slot_cnt[i]) : '0;
  end
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      stat <= '0;
      mask <= '0;
      {mdio_clk, mdio_oe, mdio_do} <= '0;
      {mdi_s1, mdi_s2} <= '0;
      tx_adr_q <= '0;
      tx_rem <= '0;
      tx_valid_q <= 1'b0;
      rr <= '0;
      irq_rx <= 1'b0;
      irq_tx <= 1'b0;
      bus.csr_do <= '0;
    end else begin
      stat <= (stat & ~w1c) | set_evt;
      mask <= wr_mask ? bus.csr_di[2:0] : mask;
      {mdio_clk, mdio_oe, mdio_do} <= wr_mdio ? {bus.csr_di[3:2], bus.csr_di[0]} : {mdio_clk, mdio_oe, mdio_do};
      mdi_s1 <= phy_mii_data;
      mdi_s2 <= mdi_s1;
      tx_adr_q <= wr_txadr ? bus.csr_di[ADDR_W+1:2] : tx_step ? tx_adr_q + 1'b1 : tx_adr_q;
      tx_rem <= wr_txrem ? bus.csr_di[COUNT_W-1:0] : tx_step ? tx_rem - 1'b1 : tx_rem;
      tx_valid_q <= bus.tx_valid;
      if (bus.rx_endframe && found) rr <= act == RR_W'(N_RX_SLOTS - 1) ? '0 : act + 1'b1;
      irq_rx <= (stat[ST_RX] & mask[ST_RX]) | (stat[ST_OVF] & mask[ST_OVF]);
      irq_tx <= stat[ST_TX] & mask[ST_TX];
      bus.csr_do <= rdata;
    end
endmodule
